ro_puf_cnt_ctrl: RTL and testbench
==================================

# ro_puf_cnt_ctrl

Measurement sequencer for the RO PUF datapath. Accepts the ring-oscillator enable (`roen`) from the PUF top-level controller. Over a fixed window it counts synchronized edge pulses from the currently selected RO pair and compares the two counts. It writes the resulting signature bit, then reports progress back through `counter_ctrl_state`, stepping the pair select through all `SIG_BITS` pairs.

## Interface
- `WIN_CYCLES`, 1024: measurement window length in `clk` cycles (≥2).
- `CNT_W`, 16: width of each edge counter.
- `SIG_BITS`, 128: signature length; number of RO pairs.
- `SEL_W`, 7: pair-select width, ≥ $clog2(`SIG_BITS`).
- `MARGIN`, 4: minimum count difference for a stable bit; used only with `RO_PUF_MARGIN_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `roen` in 1: RO enable from the PUF controller; level-sensitive.
- `ro_a_edge` in 1: single-cycle pulse per RO A rising edge; already synchronized to `clk`.
- `ro_b_edge` in 1: same, for RO B.
- `pair_sel` out `SEL_W`: index of the RO pair under measurement; drives the RO mux.
- `counter_ctrl_state` out 2: 00 IDLE, 01 COUNT, 10 COMPARE, 11 DONE.
- `sig_bit` out 1: last computed bit; valid while `sig_valid`=1.
- `sig_valid` out 1: one-cycle pulse in the COMPARE→DONE transition cycle.
- `signature` out `SIG_BITS`: accumulated signature, bit i measured with `pair_sel`=i.
- `sig_done` out 1: all `SIG_BITS` bits written; sticky until reset.
- `unstable_mask` out `SIG_BITS`: present only with `RO_PUF_MARGIN_EN`.

## Operation
- Reset values: state IDLE, `pair_sel`=0, both counters 0, window timer 0, `sig_bit`=0, `sig_valid`=0, `signature`=0, `sig_done`=0, `unstable_mask`=0.
- `counter_ctrl_state` is the registered state encoding.
- IDLE:
  - Counters and timer are held at 0.
  - If `roen`=1 and `sig_done`=0, go to COUNT.
  - If `sig_done`=1, remain in IDLE regardless of `roen`.
- COUNT:
  - `cnt_a` increments on `ro_a_edge`; `cnt_b` increments on `ro_b_edge`. Both may increment in the same cycle.
  - Each counter saturates at 2^`CNT_W`−1 and never wraps.
  - The timer increments every cycle.
  - Go to COMPARE in the cycle the timer equals `WIN_CYCLES`−1. The edge pulse in that cycle is counted.
  - If `roen` falls in COUNT: abort to IDLE. Counters are cleared, no bit is written, `pair_sel` is unchanged, and no `sig_valid` is issued.
- COMPARE, one cycle:
  - `sig_bit` ← (`cnt_a` > `cnt_b`). A tie gives 0.
  - `signature[pair_sel]` ← the same value.
  - `sig_valid` pulses.
  - Go to DONE unconditionally; `roen` is ignored in this cycle.
- DONE:
  - Hold `counter_ctrl_state`=11 until `roen`=0.
  - On the cycle `roen` is seen low: `pair_sel` increments and the state goes to IDLE.
  - If `pair_sel` was `SIG_BITS`−1, `sig_done` sets instead and `pair_sel` stays at `SIG_BITS`−1.
- Reset mid-operation clears everything immediately, including any partially written signature.

## Timing
- Cycle t: IDLE samples `roen`=1. COUNT occupies t+1 … t+`WIN_CYCLES`. COMPARE is t+`WIN_CYCLES`+1. DONE begins at t+`WIN_CYCLES`+2.
- `signature`, `sig_bit` and `sig_valid` update on the clock edge that enters DONE.
- Minimum re-arm time: DONE→IDLE needs one cycle after `roen` is seen low. A new COUNT starts no earlier than the cycle after IDLE sees `roen`=1.
- All outputs are registered. No combinational path runs from input to output.

## Configuration
- `RO_PUF_MARGIN_EN` defined:
  - In COMPARE, compute |`cnt_a`−`cnt_b`|.
  - If it is below `MARGIN`, `unstable_mask[pair_sel]` ← 1; otherwise it is written 0.
  - `sig_bit`/`signature` are computed as usual.
  - The `unstable_mask` port exists.
- `RO_PUF_MARGIN_EN` undefined: no subtractor, no `unstable_mask` port; `MARGIN` is unused.

## Test plan
All scenarios use `WIN_CYCLES`=16 and `SIG_BITS`=4 unless stated.
- Reset behaviour: assert `rst` low mid-COUNT → all outputs return to reset values asynchronously; `counter_ctrl_state`=00.
- Unequal counts: `roen`=1 from cycle t, `ro_a_edge` every cycle, `ro_b_edge` every other cycle → counts 16/8. Required: `sig_valid` at t+18, `sig_bit`=1, `signature`=4'b0001, state 11 from t+18.
- Tie and saturation: `CNT_W`=3, both edges every cycle → both counters saturate at 7. Required: `sig_bit`=0, `signature[0]`=0.
- Abort: `roen` dropped at COUNT cycle 5 → state goes to 00. Required: no `sig_valid`, `pair_sel`=0, `signature` unchanged; the next full window writes bit 0.
- Full sweep: four complete handshakes, with `roen` dropped two cycles after each state 11. Required: `pair_sel` 0→1→2→3 then holds at 3; `sig_done`=1 after the fourth; a further `roen`=1 leaves state at 00.
- With `RO_PUF_MARGIN_EN` and `MARGIN`=4, counts 10 vs 8 → `sig_bit`=1 and `unstable_mask[0]`=1. Counts 14 vs 8 → `unstable_mask[0]`=0.

Source files
------------

// File: rtl/ro_puf_cnt_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ro_puf_cnt_ctrl_if
// Description : Handshake and result bundle between the PUF top-level
//               controller (master) and the RO measurement sequencer (slave).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   roen               master->slave  RO enable, level-sensitive
//   ro_a_edge          master->slave  one-cycle pulse per RO A rising edge
//   ro_b_edge          master->slave  one-cycle pulse per RO B rising edge
//   pair_sel           slave->master  RO pair under measurement (drives RO mux)
//   counter_ctrl_state slave->master  00 IDLE, 01 COUNT, 10 COMPARE, 11 DONE
//   sig_bit            slave->master  last computed signature bit
//   sig_valid          slave->master  one-cycle pulse when sig_bit is fresh
//   signature          slave->master  accumulated signature
//   sig_done           slave->master  all signature bits written (sticky)
//   unstable_mask      slave->master  low-margin bit flags (RO_PUF_MARGIN_EN)
// Configuration macro: RO_PUF_MARGIN_EN adds the unstable_mask signal.
// ============================================================================
interface ro_puf_cnt_ctrl_if #(
  parameter int SEL_W    = 7,
  parameter int SIG_BITS = 128
);
  logic                roen;
  logic                ro_a_edge;
  logic                ro_b_edge;
  logic [SEL_W-1:0]    pair_sel;
  logic [1:0]          counter_ctrl_state;
  logic                sig_bit;
  logic                sig_valid;
  logic [SIG_BITS-1:0] signature;
  logic                sig_done;
`ifdef RO_PUF_MARGIN_EN
  logic [SIG_BITS-1:0] unstable_mask;
`endif

  // PUF top-level controller side
  modport master (
    output roen,
    output ro_a_edge,
    output ro_b_edge,
    input  pair_sel,
    input  counter_ctrl_state,
    input  sig_bit,
    input  sig_valid,
    input  signature,
`ifdef RO_PUF_MARGIN_EN
    input  unstable_mask,
`endif
    input  sig_done
  );

  // Measurement sequencer side
  modport slave (
    input  roen,
    input  ro_a_edge,
    input  ro_b_edge,
    output pair_sel,
    output counter_ctrl_state,
    output sig_bit,
    output sig_valid,
    output signature,
`ifdef RO_PUF_MARGIN_EN
    output unstable_mask,
`endif
    output sig_done
  );
endinterface : ro_puf_cnt_ctrl_if
`default_nettype wire

// File: rtl/ro_puf_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ro_puf_cnt_ctrl
// Description : RO PUF measurement sequencer. While roen is high it counts
//               synchronized edge pulses of the selected RO pair for a fixed
//               window, compares the two counts, writes one signature bit and
//               steps pair_sel through all SIG_BITS pairs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIN_CYCLES  measurement window length in clk cycles (>= 2)
//   CNT_W       width of each saturating edge counter
//   SIG_BITS    signature length / number of RO pairs
//   SEL_W       pair-select width (>= $clog2(SIG_BITS))
//   MARGIN      minimum stable count difference (RO_PUF_MARGIN_EN only)
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   bus         ro_puf_cnt_ctrl_if.slave (roen, edges in; results out)
// Configuration macro
//   RO_PUF_MARGIN_EN  adds |cnt_a-cnt_b| < MARGIN detection and the
//                     unstable_mask output; undefined builds have neither.
// ============================================================================
module ro_puf_cnt_ctrl #(
  parameter int WIN_CYCLES = 1024,
  parameter int CNT_W      = 16,
  parameter int SIG_BITS   = 128,
  parameter int SEL_W      = 7
`ifdef RO_PUF_MARGIN_EN
  ,
  parameter int MARGIN     = 4
`endif
) (
  input wire clk,
  input wire rst,
  ro_puf_cnt_ctrl_if.slave bus
);

  // --------------------------------------------------------------------------
  // State encoding doubles as the counter_ctrl_state output value
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COUNT   = 2'b01,
    ST_COMPARE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  // Timer only needs to reach WIN_CYCLES-1
  localparam int               TMR_W       = $clog2(WIN_CYCLES);
  localparam logic [TMR_W-1:0] c_win_last  = TMR_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;
  localparam logic [SEL_W-1:0] c_last_pair = SEL_W'(SIG_BITS - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt_a;
  logic [CNT_W-1:0]    r_cnt_b;
  logic [TMR_W-1:0]    r_timer;
  logic [SEL_W-1:0]    r_pair_sel;
  logic                r_sig_bit;
  logic                r_sig_valid;
  logic [SIG_BITS-1:0] r_signature;
  logic                r_sig_done;

  // Strictly greater: a tie resolves to 0
  logic w_a_gt_b;
  assign w_a_gt_b = (r_cnt_a > r_cnt_b);

  // Saturating increment enables; a counter at full scale stays there
  logic w_inc_a;
  logic w_inc_b;
  assign w_inc_a = bus.ro_a_edge && (r_cnt_a != c_cnt_max);
  assign w_inc_b = bus.ro_b_edge && (r_cnt_b != c_cnt_max);

`ifdef RO_PUF_MARGIN_EN
  // Margin compare is done one bit wider so MARGIN = 2^CNT_W still works
  localparam logic [CNT_W:0] c_margin = (CNT_W + 1)'(MARGIN);

  logic [SIG_BITS-1:0] r_unstable_mask;
  logic [CNT_W-1:0]    w_abs_diff;
  logic                w_below_margin;

  assign w_abs_diff     = w_a_gt_b ? (r_cnt_a - r_cnt_b) : (r_cnt_b - r_cnt_a);
  assign w_below_margin = ({1'b0, w_abs_diff} < c_margin);
`endif

  // --------------------------------------------------------------------------
  // Sequencer: state, counters, timer and all result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_timer     <= '0;
      r_pair_sel  <= '0;
      r_sig_bit   <= 1'b0;
      r_sig_valid <= 1'b0;
      r_signature <= '0;
      r_sig_done  <= 1'b0;
`ifdef RO_PUF_MARGIN_EN
      r_unstable_mask <= '0;
`endif
    end else begin
      // sig_valid is a single-cycle pulse, set only by COMPARE
      r_sig_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_cnt_a <= '0;
          r_cnt_b <= '0;
          r_timer <= '0;
          // Once the signature is complete the sequencer parks here
          if (bus.roen && !r_sig_done) begin
            r_state <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (!bus.roen) begin
            // Abort: drop partial counts, leave pair_sel and signature alone
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            // Edges in the final window cycle still count
            if (w_inc_a) begin
              r_cnt_a <= r_cnt_a + 1'b1;
            end
            if (w_inc_b) begin
              r_cnt_b <= r_cnt_b + 1'b1;
            end
            r_timer <= r_timer + 1'b1;
            if (r_timer == c_win_last) begin
              r_state <= ST_COMPARE;
            end
          end
        end

        ST_COMPARE: begin
          // roen is deliberately not looked at here
          r_sig_bit               <= w_a_gt_b;
          r_signature[r_pair_sel] <= w_a_gt_b;
          r_sig_valid             <= 1'b1;
`ifdef RO_PUF_MARGIN_EN
          r_unstable_mask[r_pair_sel] <= w_below_margin;
`endif
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          // Wait for the controller to acknowledge by dropping roen
          if (!bus.roen) begin
            if (r_pair_sel == c_last_pair) begin
              r_sig_done <= 1'b1;
            end else begin
              r_pair_sel <= r_pair_sel + 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from registers
  // --------------------------------------------------------------------------
  assign bus.pair_sel           = r_pair_sel;
  assign bus.counter_ctrl_state = r_state;
  assign bus.sig_bit            = r_sig_bit;
  assign bus.sig_valid          = r_sig_valid;
  assign bus.signature          = r_signature;
  assign bus.sig_done           = r_sig_done;
`ifdef RO_PUF_MARGIN_EN
  assign bus.unstable_mask      = r_unstable_mask;
`endif

endmodule : ro_puf_cnt_ctrl
`default_nettype wire

// File: tb/tb_ro_puf_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_puf_cnt_ctrl
// Description : Directed self-checking bench for ro_puf_cnt_ctrl. dut0 uses
//               CNT_W=16, dut1 uses CNT_W=3 for saturation; both use
//               WIN_CYCLES=16, SIG_BITS=4. Edge pulses are shared, each DUT
//               has its own roen. Build with RO_PUF_MARGIN_EN to add the
//               margin scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_puf_cnt_ctrl;
  localparam int WIN  = 16;
  localparam int SIGB = 4;
  localparam int SELW = 2;

  logic clk;
  logic rst;
  logic roen0;
  logic roen1;
  logic a_e;
  logic b_e;
  int   n_tests;
  int   n_fail;

  ro_puf_cnt_ctrl_if #(.SEL_W(SELW), .SIG_BITS(SIGB)) bus0 ();
  ro_puf_cnt_ctrl_if #(.SEL_W(SELW), .SIG_BITS(SIGB)) bus1 ();

  assign bus0.roen      = roen0;
  assign bus0.ro_a_edge = a_e;
  assign bus0.ro_b_edge = b_e;
  assign bus1.roen      = roen1;
  assign bus1.ro_a_edge = a_e;
  assign bus1.ro_b_edge = b_e;

  ro_puf_cnt_ctrl #(
    .WIN_CYCLES(WIN), .CNT_W(16), .SIG_BITS(SIGB), .SEL_W(SELW)
`ifdef RO_PUF_MARGIN_EN
    , .MARGIN(4)
`endif
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  ro_puf_cnt_ctrl #(
    .WIN_CYCLES(WIN), .CNT_W(3), .SIG_BITS(SIGB), .SEL_W(SELW)
`ifdef RO_PUF_MARGIN_EN
    , .MARGIN(4)
`endif
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output readers selecting dut0 (d=0) or dut1 (d=1)
  function automatic logic [1:0] st(input bit d);
    return d ? bus1.counter_ctrl_state : bus0.counter_ctrl_state;
  endfunction
  function automatic logic vld(input bit d);
    return d ? bus1.sig_valid : bus0.sig_valid;
  endfunction
  function automatic logic sbit(input bit d);
    return d ? bus1.sig_bit : bus0.sig_bit;
  endfunction
  function automatic logic [SIGB-1:0] sig(input bit d);
    return d ? bus1.signature : bus0.signature;
  endfunction
  function automatic logic [SELW-1:0] psel(input bit d);
    return d ? bus1.pair_sel : bus0.pair_sel;
  endfunction

  // One full measurement window; cycle t is the IDLE cycle that samples
  // roen=1. Leaves the bench at the first DONE cycle (t+18).
  task automatic run_window(input bit d, input logic [15:0] av, input logic [15:0] bv,
                            input string tag);
    @(negedge clk);
    if (d) roen1 = 1'b1; else roen0 = 1'b1;
    a_e = 1'b0;
    b_e = 1'b0;
    @(negedge clk);
    n_tests++;
    if (st(d) !== 2'b01) begin
      n_fail++;
      $display("FAIL %s enter_count: state got %b want 01", tag, st(d));
    end
    for (int i = 0; i < WIN; i++) begin
      a_e = av[i];
      b_e = bv[i];
      @(negedge clk);
    end
    a_e = 1'b0;
    b_e = 1'b0;
    n_tests++;
    if (st(d) !== 2'b10 || vld(d) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s compare_cycle: state/valid got %b/%b want 10/0", tag, st(d), vld(d));
    end
    @(negedge clk);
    n_tests++;
    if (st(d) !== 2'b11 || vld(d) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_t18: state/valid got %b/%b want 11/1", tag, st(d), vld(d));
    end
  endtask

  // Hold DONE two cycles, then drop roen; leaves the bench in IDLE
  task automatic release_roen(input bit d, input string tag);
    @(negedge clk);
    n_tests++;
    if (st(d) !== 2'b11 || vld(d) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_hold: state/valid got %b/%b want 11/0", tag, st(d), vld(d));
    end
    @(negedge clk);
    if (d) roen1 = 1'b0; else roen0 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (st(d) !== 2'b00) begin
      n_fail++;
      $display("FAIL %s back_idle: state got %b want 00", tag, st(d));
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    roen0 = 1'b0;
    roen1 = 1'b0;
    a_e   = 1'b0;
    b_e   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (st(0) !== 2'b00 || psel(0) !== 2'd0 || sig(0) !== 4'b0000 ||
        sbit(0) !== 1'b0 || vld(0) !== 1'b0 || bus0.sig_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: st=%b psel=%0d sig=%b bit=%b vld=%b done=%b want all 0",
               st(0), psel(0), sig(0), sbit(0), vld(0), bus0.sig_done);
    end
`ifdef RO_PUF_MARGIN_EN
    n_tests++;
    if (bus0.unstable_mask !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mask: got %b want 0000", bus0.unstable_mask);
    end
`endif
    rst = 1'b1;
  endtask

  task automatic test_unequal();
    // 16 A edges vs 8 B edges
    run_window(0, 16'hFFFF, 16'h5555, "unequal");
    n_tests++;
    if (sbit(0) !== 1'b1 || sig(0) !== 4'b0001) begin
      n_fail++;
      $display("FAIL unequal_result: bit/sig got %b/%b want 1/0001", sbit(0), sig(0));
    end
    release_roen(0, "unequal");
    n_tests++;
    if (psel(0) !== 2'd1 || bus0.sig_done !== 1'b0) begin
      n_fail++;
      $display("FAIL unequal_step: psel/done got %0d/%b want 1/0", psel(0), bus0.sig_done);
    end
  endtask

  task automatic test_tie_sat();
    // CNT_W=3: both saturate at 7 -> tie -> 0
    run_window(1, 16'hFFFF, 16'hFFFF, "tie_sat");
    n_tests++;
    if (sbit(1) !== 1'b0 || sig(1) !== 4'b0000) begin
      n_fail++;
      $display("FAIL tie_sat_result: bit/sig got %b/%b want 0/0000", sbit(1), sig(1));
    end
    release_roen(1, "tie_sat");
    // A saturates at 7 against 6 B edges; a wrapping counter would lose
    run_window(1, 16'hFFFF, 16'h003F, "sat_gt");
    n_tests++;
    if (sbit(1) !== 1'b1 || sig(1) !== 4'b0010) begin
      n_fail++;
      $display("FAIL sat_gt_result: bit/sig got %b/%b want 1/0010", sbit(1), sig(1));
    end
    release_roen(1, "sat_gt");
  endtask

  task automatic test_reset_mid_count();
    @(negedge clk);
    roen0 = 1'b1;
    a_e   = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (st(0) !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_pre: state got %b want 01", st(0));
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (st(0) !== 2'b00 || psel(0) !== 2'd0 || sig(0) !== 4'b0000 ||
        sbit(0) !== 1'b0 || vld(0) !== 1'b0 || bus0.sig_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: st=%b psel=%0d sig=%b bit=%b vld=%b done=%b want all 0",
               st(0), psel(0), sig(0), sbit(0), vld(0), bus0.sig_done);
    end
    n_tests++;
    if (sig(1) !== 4'b0000 || psel(1) !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid_dut1: sig/psel got %b/%0d want 0000/0", sig(1), psel(1));
    end
    roen0 = 1'b0;
    a_e   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_abort();
    bit saw_valid;
    saw_valid = 1'b0;
    @(negedge clk);
    roen0 = 1'b1;
    @(negedge clk);
    // Five B edges that must be discarded by the abort
    for (int i = 0; i < 5; i++) begin
      b_e = 1'b1;
      @(negedge clk);
    end
    b_e   = 1'b0;
    roen0 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (st(0) !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_state: got %b want 00", st(0));
    end
    for (int i = 0; i < 20; i++) begin
      if (vld(0) === 1'b1) saw_valid = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (saw_valid !== 1'b0 || psel(0) !== 2'd0 || sig(0) !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_effects: valid_seen/psel/sig got %b/%0d/%b want 0/0/0000",
               saw_valid, psel(0), sig(0));
    end
    // 8 A vs 3 B; leftover abort counts would make it a tie
    run_window(0, 16'h00FF, 16'h0007, "post_abort");
    n_tests++;
    if (sbit(0) !== 1'b1 || sig(0) !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_abort_result: bit/sig got %b/%b want 1/0001", sbit(0), sig(0));
    end
    release_roen(0, "post_abort");
    n_tests++;
    if (psel(0) !== 2'd1) begin
      n_fail++;
      $display("FAIL post_abort_step: psel got %0d want 1", psel(0));
    end
  endtask

  task automatic test_full_sweep();
    bit left_idle;
    // Pair 1: 4 vs 8 -> 0
    run_window(0, 16'h000F, 16'h00FF, "sweep1");
    n_tests++;
    if (sbit(0) !== 1'b0 || sig(0) !== 4'b0001) begin
      n_fail++;
      $display("FAIL sweep1_result: bit/sig got %b/%b want 0/0001", sbit(0), sig(0));
    end
    release_roen(0, "sweep1");
    n_tests++;
    if (psel(0) !== 2'd2) begin
      n_fail++;
      $display("FAIL sweep1_step: psel got %0d want 2", psel(0));
    end
    // Pair 2: 16 vs 0 -> 1
    run_window(0, 16'hFFFF, 16'h0000, "sweep2");
    n_tests++;
    if (sbit(0) !== 1'b1 || sig(0) !== 4'b0101) begin
      n_fail++;
      $display("FAIL sweep2_result: bit/sig got %b/%b want 1/0101", sbit(0), sig(0));
    end
    release_roen(0, "sweep2");
    n_tests++;
    if (psel(0) !== 2'd3 || bus0.sig_done !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep2_step: psel/done got %0d/%b want 3/0", psel(0), bus0.sig_done);
    end
    // Pair 3: 8 vs 8 tie -> 0
    run_window(0, 16'h00FF, 16'hFF00, "sweep3");
    n_tests++;
    if (sbit(0) !== 1'b0 || sig(0) !== 4'b0101) begin
      n_fail++;
      $display("FAIL sweep3_result: bit/sig got %b/%b want 0/0101", sbit(0), sig(0));
    end
    release_roen(0, "sweep3");
    n_tests++;
    if (psel(0) !== 2'd3 || bus0.sig_done !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_done: psel/done got %0d/%b want 3/1", psel(0), bus0.sig_done);
    end
    // Completed signature: roen is ignored
    left_idle = 1'b0;
    roen0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (st(0) !== 2'b00) left_idle = 1'b1;
    end
    roen0 = 1'b0;
    n_tests++;
    if (left_idle !== 1'b0 || bus0.sig_done !== 1'b1 || psel(0) !== 2'd3) begin
      n_fail++;
      $display("FAIL sweep_park: left_idle/done/psel got %b/%b/%0d want 0/1/3",
               left_idle, bus0.sig_done, psel(0));
    end
  endtask

`ifdef RO_PUF_MARGIN_EN
  task automatic test_margin();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // 10 vs 8: difference 2 < 4 -> unstable
    run_window(0, 16'h03FF, 16'h00FF, "margin_lo");
    n_tests++;
    if (sbit(0) !== 1'b1 || bus0.unstable_mask !== 4'b0001) begin
      n_fail++;
      $display("FAIL margin_lo: bit/mask got %b/%b want 1/0001", sbit(0), bus0.unstable_mask);
    end
    release_roen(0, "margin_lo");
    // 14 vs 8: difference 6 -> stable, bit 1 of mask written 0
    run_window(0, 16'h3FFF, 16'h00FF, "margin_hi");
    n_tests++;
    if (sig(0) !== 4'b0011 || bus0.unstable_mask !== 4'b0001) begin
      n_fail++;
      $display("FAIL margin_hi: sig/mask got %b/%b want 0011/0001", sig(0), bus0.unstable_mask);
    end
    release_roen(0, "margin_hi");
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_unequal();
    test_tie_sat();
    test_reset_mid_count();
    test_abort();
    test_full_sweep();
`ifdef RO_PUF_MARGIN_EN
    test_margin();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_ro_puf_cnt_ctrl
`default_nettype wire
